// File: rtl/de_write_combiner.sv
// -----------------------------------------------------------------------------
// de_write_combiner
//   Write combiner between the drawing engine's de_* pixel-write port and the
//   frame-store memory port. Byte writes to the same 32-bit word are merged
//   in a hold register. Finished words are queued in a DEPTH-entry FIFO that
//   drains to memory through a req/ack handshake.
//
//   A word leaves the hold register in one of three ways:
//   - a write to a different address evicts it;
//   - flush is high;
//   - the hold has been idle for TIMEOUT cycles.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   de_req/de_ack          engine write handshake (de_ack is a registered pulse)
//   de_addr/de_nbyte/
//   de_rnw/de_w_data       engine write: word address, active-low byte enables,
//                          read flag (reads are never acked), data
//   flush                  level request to push the hold register
//   mem_req/mem_ack        FIFO head valid / head consumed
//   mem_addr/mem_nbyte/
//   mem_rnw/mem_w_data     FIFO head contents (mem_rnw is always 0)
//   idle                   hold register and FIFO both empty
// -----------------------------------------------------------------------------

// Per-byte-lane merge: keep the held byte unless this write enables the lane.
module de_wc_lane (
  input  logic [7:0] hold_i,
  input  logic [7:0] wr_i,
  input  logic       keep_i,   // active-low byte enable of the incoming write
  output logic [7:0] merged_o
);
  assign merged_o = keep_i ? hold_i : wr_i;
endmodule

module de_write_combiner #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  input  logic        flush,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_nbyte,
  output logic        mem_rnw,
  output logic [31:0] mem_w_data,
  output logic        idle
);

  localparam int NUM_LANES = 4;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW        = AW + 1;
  localparam int TW        = $clog2(TIMEOUT + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    hold_vld_q;
  logic [17:0]             hold_addr_q;
  logic [3:0]              hold_nbyte_q;
  logic [31:0]             hold_data_q;
  logic [TW-1:0]           tmo_q;
  logic                    de_ack_q;

  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q;

  logic [17:0]             fifo_addr_q  [DEPTH];
  logic [3:0]              fifo_nbyte_q [DEPTH];
  logic [31:0]             fifo_data_q  [DEPTH];

  // ---------------------------------------------------------------------------
  // Byte-lane merge of the incoming write onto the hold register
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0][7:0] merged_data;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    de_wc_lane u_lane (
      .hold_i   (hold_data_q[8*g +: 8]),
      .wr_i     (de_w_data[8*g +: 8]),
      .keep_i   (de_nbyte[g]),
      .merged_o (merged_data[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic pop, full, can_push;
  logic wr_try, hit, accept, evict, tmo_hit, drain, push;

  always_comb begin
    pop      = (cnt_q != '0) && mem_ack;
    full     = (cnt_q == CW'(DEPTH));
    // A full FIFO still takes a push when its head leaves in the same cycle.
    can_push = !full || pop;

    // No capture in the cycle de_ack is high: the engine has not yet seen
    // the ack and still presents the write that was already taken.
    wr_try   = de_req && !de_rnw && !de_ack_q;
    hit      = hold_vld_q && (hold_addr_q == de_addr);
    accept   = wr_try && (!hold_vld_q || hit || can_push);
    evict    = accept && hold_vld_q && !hit;

    // Flush and timeout only push when no write is taken this cycle. A merge
    // that coincides with flush is pushed on the following (ack) cycle.
    tmo_hit  = (tmo_q == TW'(TIMEOUT));
    drain    = !accept && hold_vld_q && (flush || tmo_hit) && can_push;
    push     = evict || drain;
  end

  // ---------------------------------------------------------------------------
  // Hold register, timeout counter, ack and FIFO pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q   <= 1'b0;
      hold_addr_q  <= '0;
      hold_nbyte_q <= 4'b1111;
      hold_data_q  <= '0;
      tmo_q        <= '0;
      de_ack_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      de_ack_q <= accept;

      if (accept) begin
        hold_vld_q  <= 1'b1;
        hold_addr_q <= de_addr;
        tmo_q       <= '0;
        if (hit) begin
          hold_nbyte_q <= hold_nbyte_q & de_nbyte;
          hold_data_q  <= merged_data;
        end else begin
          hold_nbyte_q <= de_nbyte;
          hold_data_q  <= de_w_data;
        end
      end else if (drain) begin
        hold_vld_q   <= 1'b0;
        hold_nbyte_q <= 4'b1111;
        tmo_q        <= '0;
      end else if (hold_vld_q && !tmo_hit) begin
        // Saturates at TIMEOUT while the push is blocked by a full FIFO.
        tmo_q <= tmo_q + TW'(1);
      end

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // FIFO storage carries no reset; empty entries are masked at the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= hold_addr_q;
      fifo_nbyte_q[wr_ptr_q] <= hold_nbyte_q;
      fifo_data_q[wr_ptr_q]  <= hold_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all taken from registered state
  // ---------------------------------------------------------------------------
  assign de_ack     = de_ack_q;
  assign mem_req    = (cnt_q != '0);
  assign mem_addr   = mem_req ? fifo_addr_q[rd_ptr_q]  : 18'd0;
  assign mem_nbyte  = mem_req ? fifo_nbyte_q[rd_ptr_q] : 4'b1111;
  assign mem_w_data = mem_req ? fifo_data_q[rd_ptr_q]  : 32'd0;
  assign mem_rnw    = 1'b0;
  assign idle       = !hold_vld_q && (cnt_q == '0);

endmodule

// File: tb/tb_de_write_combiner.sv
// -----------------------------------------------------------------------------
// Testbench for de_write_combiner.
//
// Reference model: an "open word" plus a queue of closed words.
// - Every acked write either merges into the open word (same address) or
//   closes it and opens a new one.
// - flush or timeout may close the open word without a new write. A memory
//   word seen while the closed queue is empty must therefore be the open word.
// - A monitor pops the queue on every mem_req && mem_ack and compares.
// -----------------------------------------------------------------------------
module tb_de_write_combiner;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_req = 1'b0;
  logic        de_ack;
  logic [17:0] de_addr = '0;
  logic [3:0]  de_nbyte = 4'b1111;
  logic        de_rnw = 1'b0;
  logic [31:0] de_w_data = '0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [17:0] mem_addr;
  logic [3:0]  mem_nbyte;
  logic        mem_rnw;
  logic [31:0] mem_w_data;
  logic        idle;

  de_write_combiner #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de_req     (de_req),
    .de_ack     (de_ack),
    .de_addr    (de_addr),
    .de_nbyte   (de_nbyte),
    .de_rnw     (de_rnw),
    .de_w_data  (de_w_data),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_addr   (mem_addr),
    .mem_nbyte  (mem_nbyte),
    .mem_rnw    (mem_rnw),
    .mem_w_data (mem_w_data),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [17:0] a;
    logic [3:0]  nb;
    logic [31:0] d;
  } word_t;

  word_t exp_q[$];
  word_t open_w;
  bit    open_v = 0;

  task automatic model_write(input logic [17:0] a, input logic [3:0] nb,
                             input logic [31:0] d);
    if (open_v && open_w.a == a) begin
      for (int i = 0; i < 4; i++)
        if (!nb[i]) open_w.d[8*i +: 8] = d[8*i +: 8];
      open_w.nb = open_w.nb & nb;
    end else begin
      if (open_v) exp_q.push_back(open_w);
      open_w.a  = a;
      open_w.nb = nb;
      open_w.d  = d;
      open_v    = 1;
    end
  endtask

  task automatic model_close();
    if (open_v) exp_q.push_back(open_w);
    open_v = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory side: drives mem_ack at the negedge, then checks any word that
  // the next rising edge will consume.
  //   ack_mode: 0 low, 1 high, 2 random, 3 one-cycle pulse (then 0)
  // ---------------------------------------------------------------------------
  int          ack_mode = 0;
  int          pop_cnt  = 0;
  logic [17:0] last_a;
  logic [3:0]  last_nb;
  logic [31:0] last_d;

  initial begin
    word_t       e;
    bit          have;
    logic [31:0] mask;
    forever begin
      @(negedge clk);
      case (ack_mode)
        0: mem_ack = 1'b0;
        1: mem_ack = 1'b1;
        2: mem_ack = 1'($urandom_range(0, 1));
        default: begin mem_ack = 1'b1; ack_mode = 0; end
      endcase
      if (rst_n && mem_req && mem_ack) begin
        pop_cnt++;
        last_a  = mem_addr;
        last_nb = mem_nbyte;
        last_d  = mem_w_data;
        have    = 1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else if (open_v) begin e = open_w; open_v = 0; end
        else begin
          have = 0;
          checks++; errors++;
          $display("FAIL unexpected_word actual addr=%h nbyte=%b data=%h required none",
                   mem_addr, mem_nbyte, mem_w_data);
        end
        if (have) begin
          for (int i = 0; i < 4; i++) mask[8*i +: 8] = e.nb[i] ? 8'h00 : 8'hFF;
          checks++;
          if (mem_addr !== e.a || mem_nbyte !== e.nb || mem_rnw !== 1'b0 ||
              (mem_w_data & mask) !== (e.d & mask)) begin
            errors++;
            $display("FAIL mem_word actual addr=%h nbyte=%b data=%h rnw=%b required addr=%h nbyte=%b data=%h rnw=0",
                     mem_addr, mem_nbyte, mem_w_data, mem_rnw, e.a, e.nb, e.d & mask);
          end
        end
      end
    end
  end

  // de_ack is a single-cycle pulse: never high on two consecutive cycles.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && de_ack) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL de_ack_double actual=two consecutive acks required=single pulse");
        end
      end
      prev = rst_n ? de_ack : 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Engine-side helpers (called right after a negedge)
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [17:0] a, input logic [3:0] nb,
                          input logic [31:0] d);
    bit got = 0;
    de_req = 1'b1; de_rnw = 1'b0; de_addr = a; de_nbyte = nb; de_w_data = d;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (de_ack) got = 1;
    end
    de_req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL de_ack_timeout addr=%h actual=no ack required=ack", a);
    end else model_write(a, nb, d);
  endtask

  task automatic wait_idle(input bit use_flush);
    bit got = 0;
    flush = use_flush;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (idle) got = 1;
    end
    flush = 1'b0;
    chk("idle_reached", 32'(got), 32'd1);
    model_close();
    chk("model_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rnw_probe();
    bit seen = 0;
    de_req = 1'b1; de_rnw = 1'b1; de_addr = 18'($urandom);
    repeat (4) begin
      @(negedge clk);
      if (de_ack) seen = 1;
    end
    de_req = 1'b0; de_rnw = 1'b0;
    chk("read_not_acked", 32'(seen), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #900000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int p0, n;
    bit got;

    // Reset state
    #12;
    chk("rst_de_ack",    32'(de_ack),     32'd0);
    chk("rst_mem_req",   32'(mem_req),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),   32'd0);
    chk("rst_mem_nbyte", 32'(mem_nbyte),  32'hF);
    chk("rst_mem_data",  mem_w_data,      32'd0);
    chk("rst_mem_rnw",   32'(mem_rnw),    32'd0);
    chk("rst_idle",      32'(idle),       32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Four byte writes to one word, then flush -> a single merged word
    ack_mode = 1;
    p0 = pop_cnt;
    do_write(18'h00010, 4'b1110, 32'h00000011);
    do_write(18'h00010, 4'b1101, 32'h00002200);
    do_write(18'h00010, 4'b1011, 32'h00330000);
    do_write(18'h00010, 4'b0111, 32'h44000000);
    wait_idle(1);
    chk("merge_words",  32'(pop_cnt - p0), 32'd1);
    chk("merge_addr",   32'(last_a),       32'h00010);
    chk("merge_nbyte",  32'(last_nb),      32'h0);
    chk("merge_data",   last_d,            32'h44332211);
    chk("merge_idle",   32'(idle),         32'd1);

    // Two addresses, memory always ready -> two words in order
    p0 = pop_cnt;
    do_write(18'd5, 4'b1110, 32'h000000AA);
    do_write(18'd6, 4'b1110, 32'h000000BB);
    wait_idle(1);
    chk("two_words", 32'(pop_cnt - p0), 32'd2);
    chk("two_last_addr", 32'(last_a), 32'd6);

    // Back-pressure: DEPTH in FIFO + 1 in hold, then the 6th write stalls
    ack_mode = 0;
    p0 = pop_cnt;
    for (int i = 0; i < 5; i++)
      do_write(18'h00100 + 18'(i), 4'b0000, $urandom);
    de_req = 1'b1; de_addr = 18'h00105; de_nbyte = 4'b0000; de_w_data = 32'hC0FFEE05;
    got = 0;
    repeat (12) begin @(negedge clk); if (de_ack) got = 1; end
    chk("stall_6th", 32'(got), 32'd0);
    @(posedge clk); #1 ack_mode = 3;
    @(negedge clk);
    @(negedge clk);
    chk("ack_after_pulse", 32'(de_ack), 32'd1);
    de_req = 1'b0;
    if (de_ack) model_write(18'h00105, 4'b0000, 32'hC0FFEE05);
    // Simultaneous push/pop kept the FIFO at DEPTH: the next new word stalls
    de_req = 1'b1; de_addr = 18'h00106; de_nbyte = 4'b0011; de_w_data = 32'h12345678;
    got = 0;
    repeat (10) begin @(negedge clk); if (de_ack) got = 1; end
    chk("still_full", 32'(got), 32'd0);
    ack_mode = 1;
    do_write(18'h00106, 4'b0011, 32'h12345678);
    wait_idle(1);
    chk("stall_words", 32'(pop_cnt - p0), 32'd7);

    // Timeout: a lone write is pushed after TIMEOUT idle cycles
    do_write(18'h3FFFF, 4'b1110, 32'h0000005A);
    n = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); n++;
      if (mem_req) got = 1;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("timeout_addr",   32'(mem_addr), 32'h3FFFF);
    wait_idle(0);

    // Asynchronous reset with words queued
    ack_mode = 0;
    for (int i = 0; i < 4; i++)
      do_write(18'h00200 + 18'(i), 4'b0000, $urandom);
    chk("queued_req", 32'(mem_req), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req",  32'(mem_req), 32'd0);
    chk("async_rst_idle", 32'(idle),    32'd1);
    exp_q.delete();
    open_v = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 1;
    p0 = pop_cnt;
    repeat (30) @(negedge clk);
    chk("no_stale_words", 32'(pop_cnt - p0), 32'd0);
    chk("post_rst_idle",  32'(idle),         32'd1);

    // Randomised traffic against the model
    ack_mode = 2;
    for (int k = 0; k < 250; k++) begin
      int r;
      logic [17:0] a;
      r = $urandom_range(0, 19);
      if (r == 0)      wait_idle(1);
      else if (r == 1) wait_idle(0);
      else if (r == 2) rnw_probe();
      if ($urandom_range(0, 3) == 0) a = 18'($urandom);
      else                           a = 18'h00400 + 18'($urandom_range(0, 2));
      do_write(a, 4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_write_combiner.md
Name: de_write_combiner

Overview:
- Sits directly downstream of the dithering/drawing engine, between its de_* pixel-write port and the frame-store memory port.
- Accepts single-byte pixel writes (18-bit word address, active-low byte enables) and merges consecutive writes to the same word into one 32-bit store.
- Queues merged words in a small FIFO and drains them to memory through a req/ack handshake, so the engine rarely stalls on memory latency.

Parameters:
DEPTH, 4, number of merged-word FIFO entries (power of two, 2..16)
TIMEOUT, 16, idle cycles after which a partly merged word is pushed to the FIFO without waiting for a new address

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
de_req  in  1  engine write request, held high until de_ack
de_ack  out  1  one-cycle pulse: write captured this cycle
de_addr  in  18  word address of write
de_nbyte  in  4  active-low byte enables (0 = write that byte)
de_rnw  in  1  must be 0; read requests are ignored and never acked
de_w_data  in  32  write data, byte lanes per de_nbyte
flush  in  1  level: push hold register to FIFO as soon as possible
mem_req  out  1  FIFO head valid towards frame store
mem_ack  in  1  one-cycle pulse: head consumed
mem_addr  out  18  head word address
mem_nbyte  out  4  head active-low byte enables
mem_rnw  out  1  tied 0
mem_w_data  out  32  head data
idle  out  1  hold register empty and FIFO empty

Behaviour:
- Reset (rst_n low, asynchronous): hold invalid, FIFO empty, timeout counter 0; de_ack=0, mem_req=0, mem_addr=0, mem_nbyte=4'b1111, mem_w_data=0, mem_rnw=0, idle=1. Reset mid-operation discards all buffered writes.
- Hold register (addr, nbyte, data, valid) plus FIFO of DEPTH entries; mem_* are driven directly from the FIFO head (registered storage, no combinational path from de_* to mem_*).
- Write acceptance, evaluated each cycle with de_req=1, de_rnw=0, and de_ack low in the previous cycle (no double capture):
  - Hold invalid: load hold, valid=1, de_ack=1.
  - Hold valid, same addr: merge. nbyte_new = hold.nbyte AND de_nbyte; each byte lane i with de_nbyte[i]=0 takes de_w_data lane i (later write wins). de_ack=1.
  - Hold valid, different addr: push hold to FIFO and load new write into hold, de_ack=1. Allowed only if FIFO not full, or full with mem_ack this cycle (simultaneous push/pop). Otherwise de_ack=0 and the engine waits.
- Latency: de_ack is asserted in the cycle after de_req is sampled high (registered). A merged word reaches mem_req no earlier than 1 cycle after it is pushed.
- Timeout: counter resets on every accepted write and increments while hold is valid and no write is accepted. At TIMEOUT it requests a push of hold (same full rule as above). After the push hold is invalid and the counter is 0.
- flush=1: push hold when allowed. flush with hold invalid is a no-op. If flush coincides with an accepted different-addr write, push the old hold and load the new one; the new word is pushed next cycle if flush is still high.
- FIFO: circular read/write pointers, log2(DEPTH)+1-bit count.
  - mem_req = (count != 0).
  - mem_ack while mem_req=0 is ignored.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- idle = !hold.valid && count==0. Writes with de_nbyte=4'b1111 are acked and merged (no lanes change).

Test Plan:
- Reset, then four writes to addr 0x00010 with nbyte 1110,1101,1011,0111 and data bytes 0x11,0x22,0x33,0x44, then flush -> exactly one mem_req with addr 0x00010, nbyte 0000, data 0x44332211; idle=1 after mem_ack.
- Writes to addr 5 (nbyte 1110, 0xAA) then addr 6 (1110, 0xBB), mem_ack tied high -> two memory words in order, addr 5 then 6; de_ack=1 for each write.
- mem_ack held 0, engine writes to 6 distinct addresses with DEPTH=4 -> de_ack stops after the 5th write (4 in FIFO + 1 in hold); one mem_ack pulse -> 6th write acked the following cycle.
- FIFO full, incoming different-addr write and mem_ack in the same cycle -> push and pop both happen, count stays 4, no write lost.
- Single write to addr 0x3FFFF, no further activity -> pushed after exactly TIMEOUT=16 idle cycles; mem_addr 0x3FFFF.
- rst_n pulsed low with 3 words queued and mem_req high -> mem_req=0 and idle=1 immediately (asynchronous); no stale word appears after reset release.
